// File: rtl/scan_chain_loader.sv
// Loads a serial configuration chain from a stream of words while capturing the
// chain's previous contents from its tail for readback.
//
// state     | meaning
// IDLE      | waiting for start
// CLR       | one-cycle active-low pulse on sc_clear_n
// WAIT_WORD | word_ready high, waiting for the next config word
// SHIFT     | one chain bit per cycle, sc_en high
// DONE      | one-cycle done pulse, back to IDLE
`timescale 1ns/1ps
module scan_chain_loader #(
    parameter int SC_LENGTH = 5,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              clr_first,
    input  logic [WORD_W-1:0] word_i,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              sc_en,
    output logic              sc_data,
    output logic              sc_clear_n,
    input  logic              sc_data_o,
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);
    localparam int TCW = $clog2(SC_LENGTH + 1);
    localparam int WCW = $clog2(WORD_W + 1);
    localparam logic [TCW-1:0] TOT_LAST  = TCW'(SC_LENGTH - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(WORD_W - 1);

    typedef enum logic [2:0] {IDLE, CLR, WAIT_WORD, SHIFT, DONE} state_t;

    state_t            state;
    logic [TCW-1:0]    tot_cnt;
    logic [WCW-1:0]    word_cnt;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] rb_shadow;
    logic [WORD_W-1:0] shift_nxt;
    logic [WORD_W-1:0] rb_nxt;
    logic              last_bit;

    // The chain tail is captured at the same edge that shifts the chain.
    always_comb begin
        shift_nxt = shift_reg >> 1;
        rb_nxt    = rb_shadow | (WORD_W'(sc_data_o) << word_cnt);
        last_bit  = (word_cnt == WORD_LAST) || (tot_cnt == TOT_LAST);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state      <= IDLE;
            tot_cnt    <= '0;
            word_cnt   <= '0;
            shift_reg  <= '0;
            rb_shadow  <= '0;
            word_ready <= 1'b0;
            sc_en      <= 1'b0;
            sc_data    <= 1'b0;
            sc_clear_n <= 1'b1;
            rb_word    <= '0;
            rb_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tot_cnt <= '0;
                        busy    <= 1'b1;
                        if (clr_first) begin
                            state      <= CLR;
                            sc_clear_n <= 1'b0;
                        end else begin
                            state      <= WAIT_WORD;
                            word_ready <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    sc_clear_n <= 1'b1;
                    word_ready <= 1'b1;
                    state      <= WAIT_WORD;
                end
                WAIT_WORD: begin
                    if (word_valid) begin
                        shift_reg  <= word_i;
                        word_cnt   <= '0;
                        rb_shadow  <= '0;
                        word_ready <= 1'b0;
                        sc_en      <= 1'b1;
                        sc_data    <= word_i[0];
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_nxt;
                    rb_shadow <= rb_nxt;
                    word_cnt  <= word_cnt + WCW'(1);
                    tot_cnt   <= tot_cnt + TCW'(1);
                    if (last_bit) begin
                        sc_en    <= 1'b0;
                        sc_data  <= 1'b0;
                        rb_word  <= rb_nxt;
                        rb_valid <= 1'b1;
                        if (tot_cnt == TOT_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= WAIT_WORD;
                            word_ready <= 1'b1;
                        end
                    end else begin
                        sc_data <= shift_nxt[0];
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scan_chain_loader.sv
// Bench for scan_chain_loader: a 5-bit and a 12-bit chain, each driven by its own loader,
// checked every cycle against a stream model of bits, readback words and pulses.
`timescale 1ns/1ps
module tb_scan_chain_loader;
    localparam int W    = 8;
    localparam int LEN0 = 5;
    localparam int LEN1 = 12;

    logic         clk = 1'b0;
    logic         clear;
    logic [1:0]   start_v, clr_first_v, valid_v;
    logic [W-1:0] word_v [2];
    logic [1:0]   o_wr, o_en, o_data, o_clrn, o_rbv, o_busy, o_done;
    logic [W-1:0] o_rb [2];
    logic [15:0]  chain [2] = '{default: '0};

    always #5 clk = ~clk;

    scan_chain_loader #(.SC_LENGTH(LEN0), .WORD_W(W)) dut0 (
        .clk(clk), .clear(clear), .start(start_v[0]), .clr_first(clr_first_v[0]),
        .word_i(word_v[0]), .word_valid(valid_v[0]), .word_ready(o_wr[0]),
        .sc_en(o_en[0]), .sc_data(o_data[0]), .sc_clear_n(o_clrn[0]),
        .sc_data_o(chain[0][0]), .rb_word(o_rb[0]), .rb_valid(o_rbv[0]),
        .busy(o_busy[0]), .done(o_done[0]));

    scan_chain_loader #(.SC_LENGTH(LEN1), .WORD_W(W)) dut1 (
        .clk(clk), .clear(clear), .start(start_v[1]), .clr_first(clr_first_v[1]),
        .word_i(word_v[1]), .word_valid(valid_v[1]), .word_ready(o_wr[1]),
        .sc_en(o_en[1]), .sc_data(o_data[1]), .sc_clear_n(o_clrn[1]),
        .sc_data_o(chain[1][0]), .rb_word(o_rb[1]), .rb_valid(o_rbv[1]),
        .busy(o_busy[1]), .done(o_done[1]));

    function automatic int slen(input int i);
        return (i == 0) ? LEN0 : LEN1;
    endfunction

    // Target chains: new bit enters at the top, tail is bit 0.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!o_clrn[i]) chain[i] <= '0;
            else if (o_en[i]) chain[i] <= (chain[i] >> 1) | (16'(o_data[i]) << (slen(i) - 1));
        end
    end

    bit           m_busy [2], clr_due [2], done_due [2], rb_due [2], xfer [2];
    int           bits_left [2], cur_n [2], cur_pos [2], cur_wn [2], word_idx [2];
    logic [W-1:0] cur_word [2], rb_hold [2];
    logic [15:0]  old_chain [2];
    int           en_cnt [2], clrn_cnt [2], done_cnt [2], rbv_cnt [2], wr_cnt [2];
    logic [15:0]  hist [2];
    logic [W-1:0] rb_first [2], rb_last [2];
    int           n_pass = 0;
    int           n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic timeout(input string nm);
        n_total++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    function automatic bit waiting(input int i);
        return m_busy[i] && bits_left[i] > 0 && cur_n[i] == 0 && !clr_due[i];
    endfunction

    task automatic model_step(input int i);
        logic  e_en, e_data, e_wr;
        bit    nd, nr, nc;
        int    n;
        string p;
        p = $sformatf("d%0d.", i);
        if (!clear) begin
            chk({p, "rst.word_ready"}, o_wr[i], 0);
            chk({p, "rst.sc_en"}, o_en[i], 0);
            chk({p, "rst.sc_data"}, o_data[i], 0);
            chk({p, "rst.sc_clear_n"}, o_clrn[i], 1);
            chk({p, "rst.rb_word"}, o_rb[i], 0);
            chk({p, "rst.rb_valid"}, o_rbv[i], 0);
            chk({p, "rst.busy"}, o_busy[i], 0);
            chk({p, "rst.done"}, o_done[i], 0);
            m_busy[i] = 0; clr_due[i] = 0; done_due[i] = 0; rb_due[i] = 0; xfer[i] = 0;
            cur_n[i] = 0; bits_left[i] = 0; rb_hold[i] = '0;
            return;
        end
        e_en   = cur_n[i] > 0;
        e_data = e_en ? cur_word[i][cur_pos[i]] : 1'b0;
        e_wr   = waiting(i);
        chk({p, "busy"}, o_busy[i], m_busy[i]);
        chk({p, "done"}, o_done[i], done_due[i]);
        chk({p, "sc_clear_n"}, o_clrn[i], !clr_due[i]);
        chk({p, "word_ready"}, o_wr[i], e_wr);
        chk({p, "sc_en"}, o_en[i], e_en);
        chk({p, "sc_data"}, o_data[i], e_data);
        chk({p, "rb_valid"}, o_rbv[i], rb_due[i]);
        chk({p, "rb_word"}, o_rb[i], rb_hold[i]);

        if (o_en[i] === 1'b1) begin
            if (en_cnt[i] < 16) hist[i][en_cnt[i]] = o_data[i];
            en_cnt[i]++;
        end
        if (o_clrn[i] === 1'b0) clrn_cnt[i]++;
        if (o_done[i] === 1'b1) done_cnt[i]++;
        if (o_wr[i] === 1'b1) wr_cnt[i]++;
        if (o_rbv[i] === 1'b1) begin
            if (rbv_cnt[i] == 0) rb_first[i] = o_rb[i];
            rb_last[i] = o_rb[i];
            rbv_cnt[i]++;
        end

        nd = 0; nr = 0; nc = 0;
        if (cur_n[i] > 0) begin
            cur_pos[i]++;
            cur_n[i]--;
            if (cur_n[i] == 0) begin
                nr = 1;
                rb_hold[i] = W'((old_chain[i] >> (word_idx[i] * W)) & ((16'd1 << cur_wn[i]) - 16'd1));
                word_idx[i]++;
                if (bits_left[i] == 0) nd = 1;
            end
        end
        if (!m_busy[i] && start_v[i]) begin
            m_busy[i]    = 1;
            nc           = clr_first_v[i];
            bits_left[i] = slen(i);
            word_idx[i]  = 0;
            old_chain[i] = clr_first_v[i] ? 16'h0 : chain[i];
        end else if (done_due[i]) begin
            m_busy[i] = 0;
        end
        xfer[i] = 0;
        if (e_wr && valid_v[i]) begin
            n            = (bits_left[i] < W) ? bits_left[i] : W;
            cur_word[i]  = word_v[i];
            cur_n[i]     = n;
            cur_wn[i]    = n;
            cur_pos[i]   = 0;
            bits_left[i] = bits_left[i] - n;
            xfer[i]      = 1;
        end
        done_due[i] = nd;
        rb_due[i]   = nr;
        clr_due[i]  = nc;
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_seq(input int i);
        en_cnt[i] = 0; clrn_cnt[i] = 0; done_cnt[i] = 0; rbv_cnt[i] = 0; wr_cnt[i] = 0;
        hist[i] = '0; rb_first[i] = 'x; rb_last[i] = 'x;
    endtask

    task automatic load(input int i, input bit cf, input logic [W-1:0] w0, input logic [W-1:0] w1,
                        input int gap, input bit hold);
        int nw, b;
        clr_seq(i);
        nw = (slen(i) + W - 1) / W;
        start_v[i] = 1'b1;
        clr_first_v[i] = cf;
        cycle();
        if (!hold) start_v[i] = 1'b0;
        for (int k = 0; k < nw; k++) begin
            b = 0;
            while (!waiting(i) && b < 40) begin cycle(); b++; end
            if (k > 0) repeat (gap) cycle();
            valid_v[i] = 1'b1;
            word_v[i]  = (k == 0) ? w0 : w1;
            b = 0;
            while (!xfer[i] && b < 40) begin cycle(); b++; end
            if (!xfer[i]) timeout($sformatf("d%0d.word_handshake", i));
            if (hold) word_v[i] = 8'hFF;
            else begin valid_v[i] = 1'b0; word_v[i] = 8'h5A; end
        end
        b = 0;
        while (m_busy[i] && b < 60) begin cycle(); b++; end
        if (m_busy[i]) timeout($sformatf("d%0d.sequence_end", i));
        start_v[i] = 1'b0;
        valid_v[i] = 1'b0;
    endtask

    initial begin
        int b;
        clear = 1'b0;
        start_v = '0; clr_first_v = '0; valid_v = '0;
        word_v[0] = '0; word_v[1] = '0;
        for (int i = 0; i < 2; i++) clr_seq(i);
        repeat (3) cycle();
        clear = 1'b1;

        // 5-bit chain, clear first, 0x15
        load(0, 1'b1, 8'h15, 8'h00, 0, 1'b0);
        chk("t1 sc_en cycles", en_cnt[0], 5);
        chk("t1 clear cycles", clrn_cnt[0], 1);
        chk("t1 shifted bits", hist[0][4:0], 5'b10101);
        chk("t1 rb_word", rb_last[0], 8'h00);
        chk("t1 done pulses", done_cnt[0], 1);
        chk("t1 chain", chain[0][4:0], 5'h15);

        // readback of a previous load
        load(0, 1'b0, 8'h13, 8'h00, 0, 1'b0);
        chk("t2a rb_word", rb_last[0], 8'h15);
        load(0, 1'b0, 8'h0A, 8'h00, 0, 1'b0);
        chk("t2 rb_word", rb_last[0], 8'h13);
        chk("t2 rb_valid pulses", rbv_cnt[0], 1);
        chk("t2 clear cycles", clrn_cnt[0], 0);
        chk("t2 shifted bits", hist[0][4:0], 5'b01010);
        chk("t2 chain", chain[0][4:0], 5'b01010);

        // start and word_valid held high across the whole sequence
        load(0, 1'b0, 8'h1C, 8'h00, 0, 1'b1);
        chk("t3 rb_word", rb_last[0], 8'h0A);
        chk("t3 sc_en cycles", en_cnt[0], 5);
        chk("t3 done pulses", done_cnt[0], 1);
        chk("t3 chain", chain[0][4:0], 5'h1C);
        repeat (3) cycle();
        chk("t3 idle busy", o_busy[0], 0);

        // 12-bit chain, two words with a stall before the second
        load(1, 1'b1, 8'hA5, 8'hF3, 3, 1'b0);
        chk("t4 sc_en cycles", en_cnt[1], 12);
        chk("t4 shifted bits", hist[1][11:0], 12'h3A5);
        chk("t4 rb_valid pulses", rbv_cnt[1], 2);
        chk("t4 done pulses", done_cnt[1], 1);
        chk("t4 word_ready cycles", wr_cnt[1], 5);
        chk("t4 chain", chain[1][11:0], 12'h3A5);

        // partial last word reads back with zeroed upper bits
        load(1, 1'b0, 8'h12, 8'h3F, 0, 1'b0);
        chk("t5 rb first word", rb_first[1], 8'hA5);
        chk("t5 rb last word", rb_last[1], 8'h03);
        chk("t5 chain", chain[1][11:0], 12'hF12);

        // clear mid-sequence after three shifted bits
        clr_seq(0);
        start_v[0] = 1'b1; clr_first_v[0] = 1'b0;
        cycle();
        start_v[0] = 1'b0;
        b = 0;
        while (!waiting(0) && b < 20) begin cycle(); b++; end
        valid_v[0] = 1'b1; word_v[0] = 8'h02;
        b = 0;
        while (!xfer[0] && b < 20) begin cycle(); b++; end
        valid_v[0] = 1'b0;
        b = 0;
        while (en_cnt[0] < 3 && b < 20) begin cycle(); b++; end
        if (en_cnt[0] < 3) timeout("t6 three shifts");
        chk("t6 sc_en before clear", o_en[0], 1);
        #2 clear = 1'b0;
        #1;
        chk("t6 async sc_en", o_en[0], 0);
        chk("t6 async sc_data", o_data[0], 0);
        chk("t6 async busy", o_busy[0], 0);
        chk("t6 async word_ready", o_wr[0], 0);
        chk("t6 async sc_clear_n", o_clrn[0], 1);
        chk("t6 async rb_word", o_rb[0], 8'h00);
        chk("t6 async rb_valid", o_rbv[0], 0);
        chk("t6 async done", o_done[0], 0);
        repeat (2) cycle();
        chk("t6 partial chain", chain[0][4:0], 5'h0B);
        clear = 1'b1;
        load(0, 1'b1, 8'h19, 8'h00, 0, 1'b0);
        chk("t6 reload sc_en cycles", en_cnt[0], 5);
        chk("t6 reload shifted bits", hist[0][4:0], 5'h19);
        chk("t6 reload chain", chain[0][4:0], 5'h19);

        repeat (2) cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
